// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-attached byte RAM: command encodings,
// read-serializer FSM states and the default number of MISO beats per read.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int TX_BEATS_DEF = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        TX   = 1'b1
    } state_t;

endpackage

// File: rtl/spi_ram_array.sv
// Plain single-write-port byte array with a registered, enable-gated read port.
// No reset on storage or read register so it maps onto block RAM.
module spi_ram_array #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] wr_addr,
    input  logic [7:0]           wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic [7:0]           rd_data
);

    logic [7:0] mem [2**ADDR_SIZE];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register only loads on an accepted read, so it doubles as the held tx byte.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/spi_ram.sv
// Command decoder and read-return FSM sitting behind spi_slave.
// Optional feature: define SPI_RAM_ADDR_AUTO_INC_EN for auto-incrementing addresses.
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int TX_BEATS  = TX_BEATS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       cmd_err
);

    localparam int CNT_W = (TX_BEATS > 1) ? $clog2(TX_BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_BEATS - 1);

    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] operand_addr;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 tx_loaded_q, tx_loaded_d;
    logic                 cmd_err_q, cmd_err_d;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 rd_armed_q, rd_armed_d;

    logic                 wr_en;
    logic                 rd_en;
    logic [7:0]           arr_rd_data;

    assign cmd          = rx_data[9:8];
    assign operand_addr = ADDR_SIZE'(rx_data[7:0]);

    always_comb begin
        state_d     = state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_valid_d  = tx_valid_q;
        tx_loaded_d = tx_loaded_q;
        cmd_err_d   = 1'b0;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        rd_armed_d  = rd_armed_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: wr_addr_d = operand_addr;
                CMD_WR_DATA: begin
                    wr_en = 1'b1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
                    wr_addr_d = wr_addr_q + 1'b1;
`endif
                end
                CMD_RD_ADDR: begin
                    rd_addr_d  = operand_addr;
                    rd_armed_d = 1'b1;
                end
                default: begin
                    // A read while still serializing the previous byte is dropped.
                    if (state_q == TX) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        rd_en       = 1'b1;
                        rd_armed_d  = 1'b0;
                        tx_loaded_d = 1'b1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
                        rd_addr_d = rd_addr_q + 1'b1;
`else
                        cmd_err_d = ~rd_armed_q;
`endif
                    end
                end
            endcase
        end

        case (state_q)
            IDLE: begin
                if (rd_en) begin
                    state_d    = TX;
                    tx_valid_d = 1'b1;
                    tx_cnt_d   = '0;
                end
            end
            default: begin
                if (tx_cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_cnt_q    <= '0;
            tx_valid_q  <= 1'b0;
            tx_loaded_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            rd_armed_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_valid_q  <= tx_valid_d;
            tx_loaded_q <= tx_loaded_d;
            cmd_err_q   <= cmd_err_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            rd_armed_q  <= rd_armed_d;
        end
    end

    spi_ram_array #(
        .ADDR_SIZE(ADDR_SIZE)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr_q),
        .wr_data (rx_data[7:0]),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_q),
        .rd_data (arr_rd_data)
    );

    // Array read register has no reset; mask it until the first read since reset.
    assign tx_data  = tx_loaded_q ? arr_rd_data : 8'h00;
    assign tx_valid = tx_valid_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram.sv
// Directed bench for spi_ram: command decode, read serializer timing, error pulses, reset mid-read.
module tb_spi_ram;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       cmd_err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_ram #(
        .ADDR_SIZE(8),
        .TX_BEATS (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err)
    );

    // Caller sits 1ns after an edge; returns 1ns after the edge that sampled the command.
    task automatic do_cmd(input logic [1:0] c, input logic [7:0] op);
        rx_data  = {c, op};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20 && tx_valid === 1'b1; i++) tick();
        tests++;
        if (tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle: tx_valid=%b required 0", name, tx_valid);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tests++;
        if ({tx_valid, cmd_err, tx_data} !== 10'h000) begin
            fails++;
            $display("FAIL reset_outputs: valid=%b err=%b data=%h required 0 0 00", tx_valid, cmd_err, tx_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_read();
        int n;
        int errs;
        errs = 0;
        do_cmd(2'b00, 8'h13); errs += int'(cmd_err);
        do_cmd(2'b01, 8'h5A); errs += int'(cmd_err);
        do_cmd(2'b00, 8'h12); errs += int'(cmd_err);
        do_cmd(2'b01, 8'hA5); errs += int'(cmd_err);
        do_cmd(2'b10, 8'h12); errs += int'(cmd_err);
        tests++;
        if (tx_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_pre_valid: tx_valid=%b required 0", tx_valid);
        end
        do_cmd(2'b11, 8'h00); errs += int'(cmd_err);
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            fails++;
            $display("FAIL basic_first_beat: valid=%b data=%h required 1 a5", tx_valid, tx_data);
        end
        n = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            errs += int'(cmd_err);
            if (tx_valid === 1'b1) begin
                n++;
                tests++;
                if (tx_data !== 8'hA5) begin
                    fails++;
                    $display("FAIL basic_data_hold: data=%h required a5", tx_data);
                end
            end
        end
        tests++;
        if (n != 8) begin
            fails++;
            $display("FAIL basic_beats: %0d beats required 8", n);
        end
        tests++;
        if (errs != 0) begin
            fails++;
            $display("FAIL basic_cmd_err: %0d pulses required 0", errs);
        end
    endtask

    task automatic test_unarmed_read();
        logic [7:0] exp_data;
        logic       exp_err;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
        exp_data = 8'h5A;
        exp_err  = 1'b0;
`else
        exp_data = 8'hA5;
        exp_err  = 1'b1;
`endif
        do_cmd(2'b11, 8'h00);
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== exp_data || cmd_err !== exp_err) begin
            fails++;
            $display("FAIL unarmed_read: valid=%b data=%h err=%b required 1 %h %b",
                     tx_valid, tx_data, cmd_err, exp_data, exp_err);
        end
        tick();
        tests++;
        if (cmd_err !== 1'b0) begin
            fails++;
            $display("FAIL unarmed_err_width: cmd_err=%b required 0", cmd_err);
        end
        wait_idle("unarmed");
    endtask

    task automatic test_read_during_tx();
        int n;
        int errs;
        do_cmd(2'b10, 8'h12);
        do_cmd(2'b11, 8'h00);
        n = int'(tx_valid);
        do_cmd(2'b00, 8'h12); n += int'(tx_valid);
        do_cmd(2'b01, 8'h3C); n += int'(tx_valid);
        tests++;
        if (tx_data !== 8'hA5) begin
            fails++;
            $display("FAIL tx_write_hold: data=%h required a5", tx_data);
        end
        do_cmd(2'b11, 8'h00); n += int'(tx_valid);
        tests++;
        if (cmd_err !== 1'b1 || tx_data !== 8'hA5) begin
            fails++;
            $display("FAIL tx_reread_err: err=%b data=%h required 1 a5", cmd_err, tx_data);
        end
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n += int'(tx_valid);
            errs += int'(cmd_err);
        end
        tests++;
        if (n != 8 || errs != 0) begin
            fails++;
            $display("FAIL tx_reread_beats: beats=%0d extra_err=%0d required 8 0", n, errs);
        end
        do_cmd(2'b10, 8'h12);
        do_cmd(2'b11, 8'h00);
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h3C || cmd_err !== 1'b0) begin
            fails++;
            $display("FAIL tx_new_data: valid=%b data=%h err=%b required 1 3c 0", tx_valid, tx_data, cmd_err);
        end
        wait_idle("newdata");
    endtask

    task automatic test_addr_wrap();
        logic exp_err;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
        exp_err = 1'b0;
`else
        exp_err = 1'b1;
`endif
        do_cmd(2'b00, 8'hFF);
        do_cmd(2'b01, 8'h11);
        do_cmd(2'b01, 8'h22);
        do_cmd(2'b10, 8'hFF);
        do_cmd(2'b11, 8'h00);
        tests++;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
        if (tx_data !== 8'h11) begin
            fails++;
            $display("FAIL wrap_ff: data=%h required 11", tx_data);
        end
`else
        if (tx_data !== 8'h22) begin
            fails++;
            $display("FAIL wrap_ff: data=%h required 22", tx_data);
        end
`endif
        wait_idle("wrap1");
        do_cmd(2'b11, 8'h00);
        tests++;
        if (tx_data !== 8'h22 || cmd_err !== exp_err) begin
            fails++;
            $display("FAIL wrap_second: data=%h err=%b required 22 %b", tx_data, cmd_err, exp_err);
        end
        wait_idle("wrap2");
    endtask

    task automatic test_reset_mid_tx();
        int n;
        do_cmd(2'b10, 8'h12);
        do_cmd(2'b11, 8'h00);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            fails++;
            $display("FAIL rst_async: valid=%b data=%h required 0 00", tx_valid, tx_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n += int'(tx_valid);
        end
        tests++;
        if (n != 0) begin
            fails++;
            $display("FAIL rst_residual: %0d beats required 0", n);
        end
        do_cmd(2'b10, 8'h12);
        do_cmd(2'b11, 8'h00);
        tests++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h3C || cmd_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_mem_kept: valid=%b data=%h err=%b required 1 3c 0", tx_valid, tx_data, cmd_err);
        end
        wait_idle("rst");
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_unarmed_read();
        test_read_during_tx();
        test_addr_wrap();
        test_reset_mid_tx();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_ram.md
# spi_ram

Single-port synchronous byte RAM with a command decoder that consumes the 10-bit words produced by `spi_slave` (`rx_data`/`rx_valid`) and returns read bytes to it (`tx_data`/`tx_valid`). It sits directly downstream of the SPI slave and closes the read loop back into its MISO serializer. The top two bits of each received word select write-address, write-data, read-address or read-data; the low byte is the operand.

## Interface
- `ADDR_SIZE`, 8: address width; memory depth is 2**ADDR_SIZE bytes.
- `TX_BEATS`, 8: cycles `tx_valid` is held per read (one per MISO bit).
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_data` in 10: command word; [9:8] command, [7:0] operand.
- `rx_valid` in 1: `rx_data` valid this cycle (single-cycle pulse from slave).
- `tx_data` out 8: read byte, stable while `tx_valid` high.
- `tx_valid` out 1: read byte available; held exactly TX_BEATS cycles.
- `cmd_err` out 1: one-cycle pulse on an illegal command sequence.

## Operation
- Commands (decoded only when `rx_valid`=1): 00 WR_ADDR: `wr_addr` <= operand. 01 WR_DATA: `mem[wr_addr]` <= operand. 10 RD_ADDR: `rd_addr` <= operand, `rd_armed` <= 1. 11 RD_DATA: operand ignored (dummy byte); `tx_data` <= `mem[rd_addr]`, `rd_armed` <= 0.
- FSM states: IDLE, TX.
  - IDLE -> TX on accepted RD_DATA; `tx_valid` <= 1, `tx_cnt` <= 0.
  - TX: `tx_cnt` increments each cycle; TX -> IDLE when `tx_cnt` = TX_BEATS-1, `tx_valid` <= 0 on that edge.
- RD_DATA received while in TX: not executed, `tx_data`/`tx_cnt` unchanged, `cmd_err` pulses.
- WR_ADDR, WR_DATA, RD_ADDR are executed in either state; writes during TX never disturb `tx_data`.
- RD_DATA with `rd_armed`=0: read still executes from current `rd_addr`, `cmd_err` pulses (unless ADDR_AUTO_INC_EN).
- Read-during-write of same address on same edge impossible (one command per cycle); WR_DATA to `rd_addr` after a read does not alter held `tx_data`.
- Reset values: `tx_data`=0, `tx_valid`=0, `cmd_err`=0, `wr_addr`=0, `rd_addr`=0, `rd_armed`=0, `tx_cnt`=0, state IDLE. Memory array has no reset; contents survive `rst_n`.
- Reset mid-TX: `tx_valid` drops asynchronously, no residual beats after release.

## Timing
- WR_ADDR/RD_ADDR/WR_DATA take effect on the edge sampling `rx_valid`; a WR_DATA in the very next cycle uses the new address.
- RD_DATA sampled at edge N: `tx_data`/`tx_valid` visible after edge N (registered, 1-cycle latency from `rx_valid` assertion); `tx_valid` high for cycles following edges N..N+7, low after edge N+8.
- `cmd_err` registered: high for exactly the cycle after the offending edge.
- No combinational path from inputs to outputs.

## Configuration
- `SPI_RAM_ADDR_AUTO_INC_EN` defined: `wr_addr` increments (mod 2**ADDR_SIZE) after each WR_DATA; `rd_addr` increments after each executed RD_DATA; `rd_armed` check disabled (bursts legal, `cmd_err` only for RD_DATA during TX). 255 wraps to 0.
- Undefined: addresses change only via WR_ADDR/RD_ADDR; `rd_armed` check active.

## Structure
- Package `spi_ram_pkg`: command encodings `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11; state enum (IDLE, TX); default `TX_BEATS`.
- Sub-module `spi_ram_array`: plain synchronous array, one write port, one registered read port, no reset (BRAM-inferable). Decoder/FSM/counters stay in `spi_ram`.

## Test plan
- Reset, WR_ADDR 0x12, WR_DATA 0xA5, RD_ADDR 0x12, RD_DATA 0x00 -> `tx_data`=0xA5, `tx_valid` high exactly 8 cycles starting the cycle after RD_DATA, `cmd_err` never high.
- RD_DATA again without RD_ADDR -> `tx_data`=0xA5 re-read, `cmd_err` 1-cycle pulse (macro off); no pulse (macro on, reads 0x13 contents).
- Second RD_DATA 3 cycles into TX -> ignored, `tx_valid` still drops after 8th cycle, `cmd_err` pulses once.
- WR_DATA 0x3C to 0x12 during TX -> `tx_data` stays 0xA5; subsequent read returns 0x3C.
- Macro on: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22.
- Assert `rst_n`=0 on 4th TX cycle -> `tx_valid`=0 immediately, no beats after release; prior writes still readable.
